// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Turns a load/store request from EX/MEM into a single handshaked memory
// access, stalls the pipeline while it is outstanding and aborts after
// TIMEOUT cycles without an acknowledge.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] aluresult,
  input  logic [15:0] data_to_mem,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        stall,
  output logic [15:0] rdata_out,
  output logic        rdata_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Counter value seen in the last BUSY cycle allowed before aborting.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        w_req;
  logic        w_tmo_hit;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_rdata_out;
  logic        r_rdata_valid;
  logic        r_timeout;

  assign w_req     = memread | memwrite;
  assign w_tmo_hit = (r_wait_cnt == LP_WAIT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; DONE always returns to IDLE so a request still held
  // during DONE is not taken as a new access.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_next = BUSY;
      BUSY:    if (mem_ack || w_tmo_hit) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Stall is combinational so the pipeline freezes in the same cycle the
  // request is first seen.
  always_comb begin
    stall = 1'b0;
    if ((r_state == IDLE && w_req) || r_state == BUSY) stall = 1'b1;
  end

  // Request latching, wait counting and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_rdata_out   <= '0;
      r_rdata_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_timeout     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= memwrite;
            r_mem_addr  <= aluresult;
            r_mem_wdata <= data_to_mem;
            r_wait_cnt  <= '0;
          end
        end
        BUSY: begin
          // Ack is tested first so it wins over a simultaneous timeout.
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_wait_cnt <= '0;
            if (!r_mem_we) begin
              r_rdata_out   <= mem_rdata;
              r_rdata_valid <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_mem_req   <= 1'b0;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b1;
            r_rdata_out <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign rdata_out   = r_rdata_out;
  assign rdata_valid = r_rdata_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: a transaction-level model
// compared every cycle, plus literal checks per directed scenario.
module tb_dmem_access_ctrl;

  localparam int TMO = 15;

  logic        clk;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [15:0] aluresult;
  logic [15:0] data_to_mem;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        stall;
  logic [15:0] rdata_out;
  logic        rdata_valid;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .memread     (memread),
    .memwrite    (memwrite),
    .aluresult   (aluresult),
    .data_to_mem (data_to_mem),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .stall       (stall),
    .rdata_out   (rdata_out),
    .rdata_valid (rdata_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction model: an access is outstanding for some number of waited
  // cycles, then produces exactly one completion cycle.
  bit          m_busy;
  bit          m_done;
  int          m_waited;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_valid;
  logic        m_to;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_waited <= 0;
      m_we <= 0; m_addr <= 0; m_wdata <= 0; m_rdata <= 0;
      m_valid <= 0; m_to <= 0;
    end else if (m_done) begin
      m_done <= 0; m_valid <= 0; m_to <= 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy <= 0; m_done <= 1; m_waited <= 0;
        if (!m_we) begin
          m_rdata <= mem_rdata;
          m_valid <= 1;
        end
      end else if (m_waited + 1 == TMO) begin
        m_busy <= 0; m_done <= 1; m_waited <= 0;
        m_to <= 1; m_rdata <= 16'h0000;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (memread || memwrite) begin
      m_busy <= 1; m_waited <= 0;
      m_addr <= aluresult; m_wdata <= data_to_mem; m_we <= memwrite;
    end
  end

  // Per-scenario activity counters, sampled mid-cycle.
  int cnt_req, cnt_stall, cnt_valid, cnt_to;

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = m_busy || (!m_done && (memread || memwrite));
    chk("mem_req",     {15'd0, mem_req},     {15'd0, m_busy});
    chk("stall",       {15'd0, stall},       {15'd0, exp_stall});
    chk("mem_we",      {15'd0, mem_we},      {15'd0, m_we});
    chk("mem_addr",    mem_addr,             m_addr);
    chk("mem_wdata",   mem_wdata,            m_wdata);
    chk("rdata_out",   rdata_out,            m_rdata);
    chk("rdata_valid", {15'd0, rdata_valid}, {15'd0, m_valid});
    chk("timeout",     {15'd0, timeout},     {15'd0, m_to});
    chk("valid_and_timeout", {15'd0, rdata_valid & timeout}, 16'h0000);
    cnt_req   += int'(mem_req);
    cnt_stall += int'(stall);
    cnt_valid += int'(rdata_valid);
    cnt_to    += int'(timeout);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_cnt();
    cnt_req = 0; cnt_stall = 0; cnt_valid = 0; cnt_to = 0;
  endtask

  initial begin
    rst = 1; memread = 0; memwrite = 0; aluresult = 0;
    data_to_mem = 0; mem_rdata = 0; mem_ack = 0;
    clr_cnt();
    step(3);
    chk("reset_mem_req", {15'd0, mem_req}, 16'h0000);
    chk("reset_rdata", rdata_out, 16'h0000);
    chk("reset_addr", mem_addr, 16'h0000);
    rst = 0;
    step(2);

    // Read, ack on first BUSY cycle
    clr_cnt();
    memread = 1; aluresult = 16'h0040;
    step(1);
    chk("rd_addr", mem_addr, 16'h0040);
    chk("rd_we", {15'd0, mem_we}, 16'h0000);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    step(1);
    chk("rd_rdata", rdata_out, 16'hBEEF);
    chk("rd_valid", {15'd0, rdata_valid}, 16'h0001);
    mem_ack = 0; memread = 0;
    step(2);
    chk("rd_req_cycles", 16'(cnt_req), 16'd1);
    chk("rd_stall_cycles", 16'(cnt_stall), 16'd2);
    chk("rd_valid_pulses", 16'(cnt_valid), 16'd1);

    // Write, ack on 4th BUSY cycle
    clr_cnt();
    memwrite = 1; aluresult = 16'h0012; data_to_mem = 16'h1234;
    step(1);
    step(3);
    chk("wr_wdata", mem_wdata, 16'h1234);
    chk("wr_we", {15'd0, mem_we}, 16'h0001);
    mem_ack = 1;
    step(1);
    mem_ack = 0; memwrite = 0;
    step(2);
    chk("wr_req_cycles", 16'(cnt_req), 16'd4);
    chk("wr_stall_cycles", 16'(cnt_stall), 16'd5);
    chk("wr_valid_pulses", 16'(cnt_valid), 16'd0);
    chk("wr_rdata_held", rdata_out, 16'hBEEF);

    // Read with no ack: timeout
    clr_cnt();
    memread = 1; aluresult = 16'h0020;
    step(15);
    step(1);
    chk("to_flag", {15'd0, timeout}, 16'h0001);
    chk("to_rdata", rdata_out, 16'h0000);
    memread = 0;
    step(2);
    chk("to_req_cycles", 16'(cnt_req), 16'd15);
    chk("to_pulses", 16'(cnt_to), 16'd1);
    chk("to_valid_pulses", 16'(cnt_valid), 16'd0);

    // Ack on 15th BUSY cycle wins over timeout
    clr_cnt();
    memread = 1; aluresult = 16'h0030;
    step(15);
    mem_ack = 1; mem_rdata = 16'h00A5;
    step(1);
    chk("race_valid", {15'd0, rdata_valid}, 16'h0001);
    chk("race_rdata", rdata_out, 16'h00A5);
    chk("race_timeout", {15'd0, timeout}, 16'h0000);
    mem_ack = 0; memread = 0;
    step(2);
    chk("race_req_cycles", 16'(cnt_req), 16'd15);
    chk("race_to_pulses", 16'(cnt_to), 16'd0);

    // Back-to-back: request held through DONE, then new address
    clr_cnt();
    memread = 1; aluresult = 16'h0040;
    step(1);
    chk("b2b_addr0", mem_addr, 16'h0040);
    mem_ack = 1; mem_rdata = 16'h1111;
    step(1);
    mem_ack = 0;
    chk("b2b_done_stall", {15'd0, stall}, 16'h0000);
    step(1);
    aluresult = 16'h0044;
    step(1);
    chk("b2b_addr1", mem_addr, 16'h0044);
    mem_ack = 1; mem_rdata = 16'h2222;
    step(1);
    mem_ack = 0; memread = 0;
    step(2);
    chk("b2b_req_cycles", 16'(cnt_req), 16'd2);
    chk("b2b_valid_pulses", 16'(cnt_valid), 16'd2);
    chk("b2b_rdata", rdata_out, 16'h2222);

    // Reset in BUSY cycle 2, then a stray ack
    clr_cnt();
    memread = 1; aluresult = 16'h0050;
    step(2);
    #1;
    rst = 1; memread = 0;
    #1;
    chk("rst_async_req", {15'd0, mem_req}, 16'h0000);
    chk("rst_async_addr", mem_addr, 16'h0000);
    chk("rst_async_rdata", rdata_out, 16'h0000);
    chk("rst_async_stall", {15'd0, stall}, 16'h0000);
    step(1);
    rst = 0;
    mem_ack = 1; mem_rdata = 16'h5555;
    step(2);
    mem_ack = 0;
    step(2);
    chk("rst_req_cycles", 16'(cnt_req), 16'd1);
    chk("rst_valid_pulses", 16'(cnt_valid), 16'd0);
    chk("rst_rdata_after", rdata_out, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
